// File: rtl/sw_wavefront_sched_if.sv
// Handshake/bus bundle between the Smith-Waterman wavefront scheduler and its
// PE array plus inter-pass boundary row buffer.
interface sw_wavefront_sched_if #(
    parameter int N_PE            = 4,
    parameter int WIDTH_SCORE     = 8,
    parameter int WIDTH_POS_REF   = 7,
    parameter int WIDTH_POS_QUERY = 6
) ();
    logic                        start;
    logic                        hold;
    logic                        busy;
    logic [N_PE-1:0]             pe_valid;
    logic [WIDTH_POS_REF-1:0]    ref_addr;
    logic [WIDTH_POS_QUERY-1:0]  query_base;
    logic                        first_pass;
    logic                        bnd_rd_en;
    logic [WIDTH_POS_REF-1:0]    bnd_rd_addr;
    logic                        bnd_wr_en;
    logic [WIDTH_POS_REF-1:0]    bnd_wr_addr;
    logic [N_PE*WIDTH_SCORE-1:0] pe_h;
    logic                        finish;
    logic [WIDTH_SCORE-1:0]      max;
    logic [WIDTH_POS_REF-1:0]    pos_ref;
    logic [WIDTH_POS_QUERY-1:0]  pos_query;

    modport master (
        input  start, hold, pe_h,
        output busy, pe_valid, ref_addr, query_base, first_pass,
               bnd_rd_en, bnd_rd_addr, bnd_wr_en, bnd_wr_addr,
               finish, max, pos_ref, pos_query
    );

    modport slave (
        output start, hold, pe_h,
        input  busy, pe_valid, ref_addr, query_base, first_pass,
               bnd_rd_en, bnd_rd_addr, bnd_wr_en, bnd_wr_addr,
               finish, max, pos_ref, pos_query
    );
endinterface

// File: rtl/sw_wavefront_sched.sv
// Sequences a linear Smith-Waterman PE array over the score matrix in passes of
// N_PE rows, streaming skewed reference columns and tracking the best H score.
module sw_wavefront_sched #(
    parameter int LEN_REF         = 64,
    parameter int LEN_QUERY       = 48,
    parameter int N_PE            = 4,
    parameter int WIDTH_SCORE     = 8,
    parameter int WIDTH_POS_REF   = 7,
    parameter int WIDTH_POS_QUERY = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    sw_wavefront_sched_if.master bus
);
    localparam int P_CNT  = LEN_QUERY / N_PE;
    localparam int T_CNT  = LEN_REF + N_PE - 1;
    localparam int T_W    = $clog2(T_CNT + 1);
    localparam int PASS_W = $clog2(P_CNT + 1);

    localparam logic [T_W-1:0]    T_LAST = T_W'(T_CNT - 1);
    localparam logic [T_W-1:0]    T_REF  = T_W'(LEN_REF);
    localparam logic [T_W-1:0]    T_SKEW = T_W'(N_PE - 1);
    localparam logic [PASS_W-1:0] P_LAST = PASS_W'(P_CNT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                    state_q, state_d;
    logic [T_W-1:0]                t_q, t_d;
    logic [PASS_W-1:0]             pass_q, pass_d;
    logic [N_PE-1:0]               vld_q, vld_d;
    logic [WIDTH_POS_REF-1:0]      col_q [N_PE];
    logic [WIDTH_POS_REF-1:0]      col_d [N_PE];
    logic [WIDTH_POS_QUERY-1:0]    row_q [N_PE];
    logic [WIDTH_POS_QUERY-1:0]    row_d [N_PE];
    logic signed [WIDTH_SCORE-1:0] max_q, max_d;
    logic [WIDTH_POS_REF-1:0]      pos_ref_q, pos_ref_d;
    logic [WIDTH_POS_QUERY-1:0]    pos_query_q, pos_query_d;

    logic                          run_s;
    logic                          accept_s;
    logic [N_PE-1:0]               pe_valid_s;
    logic [N_PE-1:0]               win_s;
    logic [T_W-1:0]                tk_s [N_PE];
    logic [WIDTH_POS_QUERY-1:0]    query_base_s;
    logic signed [WIDTH_SCORE-1:0] h_s [N_PE];

    // Wavefront skew: PE k works on column t-k of row pass*N_PE+k.
    always_comb begin
        run_s        = (state_q == ST_RUN);
        accept_s     = (state_q == ST_IDLE) & bus.start;
        query_base_s = WIDTH_POS_QUERY'(pass_q) * WIDTH_POS_QUERY'(N_PE);
        for (int k = 0; k < N_PE; k++) begin
            tk_s[k]       = t_q - T_W'(k);
            pe_valid_s[k] = run_s & ~bus.hold & (t_q >= T_W'(k)) & (tk_s[k] < T_REF);
            vld_d[k]      = pe_valid_s[k];
            col_d[k]      = WIDTH_POS_REF'(tk_s[k]);
            row_d[k]      = query_base_s + WIDTH_POS_QUERY'(k);
        end
    end

    // Pass/column sequencing and IDLE->RUN->FLUSH->DONE control.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    t_d     = '0;
                    pass_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.hold) begin
                    t_d = t_q;
                end else if (t_q == T_LAST) begin
                    t_d = '0;
                    if (pass_q == P_LAST) begin
                        state_d = ST_FLUSH;
                        pass_d  = '0;
                    end else begin
                        pass_d = pass_q + PASS_W'(1);
                    end
                end else begin
                    t_d = t_q + T_W'(1);
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Running max: chained strict compare so the lowest PE wins same-cycle ties.
    always_comb begin
        max_d       = max_q;
        pos_ref_d   = pos_ref_q;
        pos_query_d = pos_query_q;
        win_s       = '0;
        for (int k = 0; k < N_PE; k++) begin
            h_s[k] = bus.pe_h[k*WIDTH_SCORE +: WIDTH_SCORE];
        end
        if (accept_s) begin
            max_d       = '0;
            pos_ref_d   = '0;
            pos_query_d = '0;
        end else begin
            for (int k = 0; k < N_PE; k++) begin
                win_s[k]    = vld_q[k] & (h_s[k] > max_d);
                max_d       = win_s[k] ? h_s[k] : max_d;
                pos_ref_d   = win_s[k] ? (col_q[k] + WIDTH_POS_REF'(1)) : pos_ref_d;
                pos_query_d = win_s[k] ? (row_q[k] + WIDTH_POS_QUERY'(1)) : pos_query_d;
            end
        end
    end

    // State, counters, compare-stage pipeline and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            t_q         <= '0;
            pass_q      <= '0;
            vld_q       <= '0;
            max_q       <= '0;
            pos_ref_q   <= '0;
            pos_query_q <= '0;
            for (int k = 0; k < N_PE; k++) begin
                col_q[k] <= '0;
                row_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            pass_q      <= pass_d;
            vld_q       <= vld_d;
            max_q       <= max_d;
            pos_ref_q   <= pos_ref_d;
            pos_query_q <= pos_query_d;
            col_q       <= col_d;
            row_q       <= row_d;
        end
    end

    assign bus.busy        = (state_q == ST_RUN) | (state_q == ST_FLUSH);
    assign bus.finish      = (state_q == ST_DONE);
    assign bus.pe_valid    = pe_valid_s;
    assign bus.ref_addr    = (t_q < T_REF) ? WIDTH_POS_REF'(t_q) : WIDTH_POS_REF'(LEN_REF - 1);
    assign bus.query_base  = query_base_s;
    assign bus.first_pass  = run_s & (pass_q == '0);
    assign bus.bnd_rd_en   = pe_valid_s[0] & (pass_q != '0);
    assign bus.bnd_rd_addr = WIDTH_POS_REF'(t_q);
    assign bus.bnd_wr_en   = pe_valid_s[N_PE-1] & (pass_q != P_LAST);
    // Gated to zero before the last PE reaches column 0 so reset leaves it at 0.
    assign bus.bnd_wr_addr = (t_q >= T_SKEW) ? WIDTH_POS_REF'(t_q - T_SKEW) : '0;
    assign bus.max         = max_q;
    assign bus.pos_ref     = pos_ref_q;
    assign bus.pos_query   = pos_query_q;
endmodule

// File: tb/tb_sw_wavefront_sched.sv
// Self-checking bench for sw_wavefront_sched: a pass/column level model drives
// PE results and predicts every output; literal results pin the model.
module tb_sw_wavefront_sched;
    localparam int LEN_REF = 64;
    localparam int N_PE    = 4;
    localparam int WS      = 8;
    localparam int P_CNT   = 12;
    localparam int T_CNT   = 67;

    logic clk = 1'b0;
    logic reset;

    sw_wavefront_sched_if bus ();
    sw_wavefront_sched dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc;
    bit chk_en;
    int mode;
    bit garbage;

    int ph, adv;
    int cur_max, cur_r, cur_q, tgt_max, tgt_r, tgt_q;
    logic [N_PE-1:0] prev_valid;
    int prev_row [N_PE];
    int prev_col [N_PE];

    bit exp_busy, exp_finish, exp_first, exp_rd, exp_wr, exp_run, exp_res;
    logic [N_PE-1:0] exp_valid;
    int exp_pass, exp_t, exp_ref_addr, exp_qbase, exp_rd_addr, exp_wr_addr;
    int exp_max, exp_r, exp_q;

    int fin_cnt, fin_cyc, busy_cnt;
    int rd_cnt [P_CNT];
    int wr_cnt [P_CNT];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Score landscape returned by the bench's PE array, per test mode.
    function automatic int hval(input int md, input int row, input int col);
        case (md)
            1:       return (row == 14 && col == 10) ? 5 : -2;
            2:       return ((row == 0 && col == 5) || (row == 20 && col == 30)) ? 7 : (row + col) % 5;
            3:       return ((row == 9 && col == 39) || (row == 11 && col == 37)) ? 9 : 3;
            default: return 0;
        endcase
    endfunction

    // Best cell in evaluation order (pass, wavefront step, PE index); strict > keeps the first.
    function automatic void best(input int md, output int bm, output int br, output int bq);
        bm = 0; br = 0; bq = 0;
        for (int p = 0; p < P_CNT; p++) begin
            for (int t = 0; t < T_CNT; t++) begin
                for (int k = 0; k < N_PE; k++) begin
                    int col, row, h;
                    col = t - k;
                    row = p * N_PE + k;
                    if (col >= 0 && col < LEN_REF) begin
                        h = hval(md, row, col);
                        if (h > bm) begin
                            bm = h; br = col + 1; bq = row + 1;
                        end
                    end
                end
            end
        end
    endfunction

    // One clock cycle: drive inputs, publish expectations, advance the model.
    task automatic do_cycle(input bit st, input bit hd);
        int mp, mt;
        logic [N_PE*WS-1:0] h;
        mp = adv / T_CNT;
        mt = adv % T_CNT;
        for (int k = 0; k < N_PE; k++) begin
            h[k*WS +: WS] = prev_valid[k] ? WS'(hval(mode, prev_row[k], prev_col[k]))
                                          : (garbage ? WS'(100) : WS'(0));
        end
        bus.start = st;
        bus.hold  = hd;
        bus.pe_h  = h;
        exp_run    = (ph == 1);
        exp_busy   = (ph == 1) || (ph == 2);
        exp_finish = (ph == 3);
        exp_pass   = mp;
        exp_t      = mt;
        for (int k = 0; k < N_PE; k++) begin
            exp_valid[k] = (ph == 1) && !hd && (mt >= k) && (mt - k < LEN_REF);
        end
        exp_first    = (ph == 1) && (mp == 0);
        exp_rd       = exp_valid[0] && (mp != 0);
        exp_wr       = exp_valid[N_PE-1] && (mp != P_CNT - 1);
        exp_ref_addr = (mt < LEN_REF) ? mt : LEN_REF - 1;
        exp_qbase    = mp * N_PE;
        exp_rd_addr  = mt;
        exp_wr_addr  = mt - (N_PE - 1);
        exp_res      = (ph == 0) || (ph == 3) || (ph == 1 && adv == 0);
        exp_max      = (ph == 3) ? tgt_max : ((ph == 0) ? cur_max : 0);
        exp_r        = (ph == 3) ? tgt_r   : ((ph == 0) ? cur_r   : 0);
        exp_q        = (ph == 3) ? tgt_q   : ((ph == 0) ? cur_q   : 0);
        for (int k = 0; k < N_PE; k++) begin
            prev_valid[k] = exp_valid[k];
            prev_row[k]   = mp * N_PE + k;
            prev_col[k]   = mt - k;
        end
        @(posedge clk);
        #1;
        cyc++;
        case (ph)
            0: if (st) begin ph = 1; adv = 0; end
            1: if (!hd) begin adv++; if (adv == P_CNT * T_CNT) ph = 2; end
            2: ph = 3;
            default: begin ph = 0; cur_max = tgt_max; cur_r = tgt_r; cur_q = tgt_q; end
        endcase
    endtask

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", bus.busy, exp_busy);
            chk("finish", bus.finish, exp_finish);
            chk("pe_valid", bus.pe_valid, exp_valid);
            chk("first_pass", bus.first_pass, exp_first);
            chk("bnd_rd_en", bus.bnd_rd_en, exp_rd);
            chk("bnd_wr_en", bus.bnd_wr_en, exp_wr);
            if (exp_run) begin
                chk("ref_addr", bus.ref_addr, exp_ref_addr);
                chk("query_base", bus.query_base, exp_qbase);
            end
            if (exp_rd) chk("bnd_rd_addr", bus.bnd_rd_addr, exp_rd_addr);
            if (exp_wr) chk("bnd_wr_addr", bus.bnd_wr_addr, exp_wr_addr);
            if (exp_res) begin
                chk("max", bus.max, exp_max);
                chk("pos_ref", bus.pos_ref, exp_r);
                chk("pos_query", bus.pos_query, exp_q);
            end
            if (mode == 1 && exp_run && exp_pass == 3 && exp_t == 12 && bus.pe_valid[2])
                chk("ref_addr_pe2_col10", bus.ref_addr, 12);
            if (bus.busy) busy_cnt++;
            if (bus.finish) begin fin_cnt++; fin_cyc = cyc; end
            if (bus.bnd_rd_en && exp_pass < P_CNT) begin
                chk("bnd_rd_seq", bus.bnd_rd_addr, rd_cnt[exp_pass]);
                rd_cnt[exp_pass]++;
            end
            if (bus.bnd_wr_en && exp_pass < P_CNT) begin
                chk("bnd_wr_seq", bus.bnd_wr_addr, wr_cnt[exp_pass]);
                wr_cnt[exp_pass]++;
            end
        end
    end

    task automatic run_test(input string tag, input int md, input bit garb, input bit use_hold,
                            input int rst_at, input int lit_max, input int lit_r, input int lit_q,
                            input int lit_fin);
        int hold_cnt, budget;
        bit hd;
        mode = md;
        garbage = garb;
        best(md, tgt_max, tgt_r, tgt_q);
        fin_cnt = 0; fin_cyc = -1; busy_cnt = 0; hold_cnt = 0; budget = 0;
        for (int p = 0; p < P_CNT; p++) begin rd_cnt[p] = 0; wr_cnt[p] = 0; end
        cyc = 0;
        do_cycle(1'b1, 1'b0);
        while (ph != 0 && budget < 2000) begin
            budget++;
            if (rst_at > 0 && cyc == rst_at) begin
                chk_en = 1'b0;
                #2;
                reset = 1'b1;
                #1;
                chk({tag, "_rst_busy"}, bus.busy, 0);
                chk({tag, "_rst_finish"}, bus.finish, 0);
                chk({tag, "_rst_pe_valid"}, bus.pe_valid, 0);
                chk({tag, "_rst_max"}, bus.max, 0);
                chk({tag, "_rst_pos_ref"}, bus.pos_ref, 0);
                chk({tag, "_rst_pos_query"}, bus.pos_query, 0);
                chk({tag, "_rst_first_pass"}, bus.first_pass, 0);
                chk({tag, "_rst_query_base"}, bus.query_base, 0);
                chk({tag, "_rst_ref_addr"}, bus.ref_addr, 0);
                chk({tag, "_rst_bnd_wr_addr"}, bus.bnd_wr_addr, 0);
                @(posedge clk);
                #1;
                reset = 1'b0;
                bus.start = 1'b0; bus.hold = 1'b0;
                ph = 0; adv = 0; prev_valid = '0;
                cur_max = 0; cur_r = 0; cur_q = 0;
                fin_cnt = 0;
                chk_en = 1'b1;
                repeat (5) do_cycle(1'b0, 1'b0);
                chk({tag, "_no_finish"}, fin_cnt, 0);
                return;
            end
            hd = use_hold && (ph == 1) && (adv == 5 * T_CNT + 30) && (hold_cnt < 10);
            if (hd) hold_cnt++;
            do_cycle(1'b0, hd);
        end
        chk({tag, "_timeout"}, ph, 0);
        chk({tag, "_finish_pulses"}, fin_cnt, 1);
        chk({tag, "_finish_cycle"}, fin_cyc, lit_fin);
        chk({tag, "_busy_cycles"}, busy_cnt, lit_fin - 1);
        chk({tag, "_max_lit"}, bus.max, lit_max);
        chk({tag, "_pos_ref_lit"}, bus.pos_ref, lit_r);
        chk({tag, "_pos_query_lit"}, bus.pos_query, lit_q);
        for (int p = 0; p < P_CNT; p++) begin
            chk({tag, "_rd_count"}, rd_cnt[p], (p == 0) ? 0 : 64);
            chk({tag, "_wr_count"}, wr_cnt[p], (p == P_CNT - 1) ? 0 : 64);
        end
        repeat (3) do_cycle(1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.hold = 1'b0; bus.pe_h = '0;
        chk_en = 1'b0; ph = 0; adv = 0; prev_valid = '0;
        cur_max = 0; cur_r = 0; cur_q = 0; tgt_max = 0; tgt_r = 0; tgt_q = 0;
        mode = 0; garbage = 1'b0; cyc = 0;
        #2;
        chk("reset_busy", bus.busy, 0);
        chk("reset_finish", bus.finish, 0);
        chk("reset_pe_valid", bus.pe_valid, 0);
        chk("reset_max", bus.max, 0);
        chk("reset_pos_ref", bus.pos_ref, 0);
        chk("reset_pos_query", bus.pos_query, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
        repeat (2) do_cycle(1'b0, 1'b0);
        run_test("allzero",    0, 1'b0, 1'b0, 0,   0,  0,  0, 806);
        run_test("single",     1, 1'b1, 1'b0, 0,   5, 11, 15, 806);
        run_test("tie_later",  2, 1'b1, 1'b0, 0,   7,  6,  1, 806);
        run_test("same_cycle", 3, 1'b1, 1'b0, 0,   9, 40, 10, 806);
        run_test("hold10",     1, 1'b1, 1'b1, 0,   5, 11, 15, 816);
        run_test("reset400",   2, 1'b1, 1'b0, 400, 0,  0,  0, 0);
        run_test("after_rst",  3, 1'b1, 1'b0, 0,   9, 40, 10, 806);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
